// File: rtl/fix_c_div.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fix_c_div                                                   |
// | Description : Fixed-point complex divider, Q = a*conj(b) / |b|^2.         |
// |               Non-pipelined: one operation in flight, sequenced by an     |
// |               IDLE -> MULT -> DIV -> SAT -> DONE state machine. Both      |
// |               quotient components are produced by parallel restoring      |
// |               dividers, one quotient bit per cycle.                       |
// | Ports       : clk, rst_n (async, active-low)                              |
// |               in_valid / in_ready        operand handshake                |
// |               opa_R, opa_I, opb_R, opb_I signed IN_WIDTH operands         |
// |               out_valid / out_ready      result handshake                 |
// |               out_R, out_I               signed OUT_WIDTH quotient,       |
// |                                          scaled by 2^FRAC_BITS            |
// |               sat                        a component was clamped          |
// |               div_zero                   divisor was 0+0i                 |
// | Options     : FIX_C_DIV_ROUND_EN - round magnitudes half away from zero   |
// |               (one extra DIV cycle); default build truncates toward zero. |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module fix_c_div #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16,
  parameter int FRAC_BITS = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  opa_R,
  input  logic [IN_WIDTH-1:0]  opa_I,
  input  logic [IN_WIDTH-1:0]  opb_R,
  input  logic [IN_WIDTH-1:0]  opb_I,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_R,
  output logic [OUT_WIDTH-1:0] out_I,
  output logic                 sat,
  output logic                 div_zero
);

  localparam int N_WIDTH  = 2*IN_WIDTH + 1;   // signed numerator width
  localparam int D_WIDTH  = 2*IN_WIDTH;       // unsigned denominator width
  localparam int NUM_ITER = N_WIDTH + FRAC_BITS;
`ifdef FIX_C_DIV_ROUND_EN
  // One extra quotient bit below the LSB drives the rounding decision.
  localparam int DIV_ITER = NUM_ITER + 1;
`else
  localparam int DIV_ITER = NUM_ITER;
`endif
  // The dividend |N| << shift is exactly DIV_ITER bits wide, so the
  // dividend register doubles as the quotient register as bits shift out.
  localparam int Q_WIDTH    = DIV_ITER;
  localparam int SHIFT      = Q_WIDTH - N_WIDTH;
  localparam int ITER_WIDTH = $clog2(DIV_ITER + 1);

  localparam logic [ITER_WIDTH-1:0] LAST_ITER = ITER_WIDTH'(DIV_ITER - 1);
  localparam logic [Q_WIDTH:0]      POS_LIM   = (Q_WIDTH+1)'((64'd1 << (OUT_WIDTH-1)) - 64'd1);
  localparam logic [Q_WIDTH:0]      NEG_LIM   = (Q_WIDTH+1)'(64'd1 << (OUT_WIDTH-1));
  localparam logic [OUT_WIDTH-1:0]  POS_OUT   = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0]  NEG_OUT   = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULT = 3'd1,
    DIV  = 3'd2,
    SAT  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state;
  state_t next_state;

  // Captured operands
  logic signed [IN_WIDTH-1:0] op_a_re;
  logic signed [IN_WIDTH-1:0] op_a_im;
  logic signed [IN_WIDTH-1:0] op_b_re;
  logic signed [IN_WIDTH-1:0] op_b_im;

  // Divider state
  logic [Q_WIDTH-1:0]    dq_re;
  logic [Q_WIDTH-1:0]    dq_im;
  logic [D_WIDTH-1:0]    rem_re;
  logic [D_WIDTH-1:0]    rem_im;
  logic [D_WIDTH-1:0]    divisor;
  logic                  neg_re;
  logic                  neg_im;
  logic                  dz;
  logic [ITER_WIDTH-1:0] iter;

  // Products, numerators, denominator
  logic signed [D_WIDTH-1:0] p_ar_br;
  logic signed [D_WIDTH-1:0] p_ai_bi;
  logic signed [D_WIDTH-1:0] p_ai_br;
  logic signed [D_WIDTH-1:0] p_ar_bi;
  logic signed [D_WIDTH-1:0] p_br_br;
  logic signed [D_WIDTH-1:0] p_bi_bi;
  logic signed [N_WIDTH-1:0] n_re;
  logic signed [N_WIDTH-1:0] n_im;
  logic [N_WIDTH-1:0]        n_re_mag;
  logic [N_WIDTH-1:0]        n_im_mag;
  logic [D_WIDTH-1:0]        d_sum;

  // Final magnitude and clamp results
  logic [Q_WIDTH:0]     mag_re;
  logic [Q_WIDTH:0]     mag_im;
  logic                 sat_re;
  logic                 sat_im;
  logic [OUT_WIDTH-1:0] val_re;
  logic [OUT_WIDTH-1:0] val_im;

  // One restoring-division step. Returns {next remainder, next dividend/quotient}.
  function automatic logic [D_WIDTH+Q_WIDTH-1:0] div_step(
    input logic [D_WIDTH-1:0] rem,
    input logic [Q_WIDTH-1:0] dq,
    input logic [D_WIDTH-1:0] dvs
  );
    logic [D_WIDTH:0]   trial;
    logic               ge;
    logic [D_WIDTH-1:0] rem_n;
    trial = {rem, dq[Q_WIDTH-1]};
    ge    = (trial >= {1'b0, dvs});
    // After a successful subtract the remainder is below dvs, so the
    // top bit of the difference is always zero and can be dropped.
    rem_n = ge ? D_WIDTH'(trial - {1'b0, dvs}) : trial[D_WIDTH-1:0];
    return {rem_n, dq[Q_WIDTH-2:0], ge};
  endfunction

  // Apply sign to a magnitude and clamp. Returns {clamped, value}.
  // Negative magnitudes may reach 2^(OUT_WIDTH-1); a zero magnitude
  // negates to zero, so no negative-zero artefact can appear.
  function automatic logic [OUT_WIDTH:0] clamp(
    input logic [Q_WIDTH:0] mag,
    input logic             neg
  );
    logic                 s;
    logic [OUT_WIDTH-1:0] v;
    if (neg) begin
      s = (mag > NEG_LIM);
      v = s ? NEG_OUT : -mag[OUT_WIDTH-1:0];
    end else begin
      s = (mag > POS_LIM);
      v = s ? POS_OUT : mag[OUT_WIDTH-1:0];
    end
    return {s, v};
  endfunction

  // Operands are widened before multiplying so -2^(IN_WIDTH-1) squared
  // and the sums of two such products stay exact.
  always_comb begin
    p_ar_br  = D_WIDTH'(op_a_re) * D_WIDTH'(op_b_re);
    p_ai_bi  = D_WIDTH'(op_a_im) * D_WIDTH'(op_b_im);
    p_ai_br  = D_WIDTH'(op_a_im) * D_WIDTH'(op_b_re);
    p_ar_bi  = D_WIDTH'(op_a_re) * D_WIDTH'(op_b_im);
    p_br_br  = D_WIDTH'(op_b_re) * D_WIDTH'(op_b_re);
    p_bi_bi  = D_WIDTH'(op_b_im) * D_WIDTH'(op_b_im);
    n_re     = N_WIDTH'(p_ar_br) + N_WIDTH'(p_ai_bi);
    n_im     = N_WIDTH'(p_ai_br) - N_WIDTH'(p_ar_bi);
    n_re_mag = n_re[N_WIDTH-1] ? $unsigned(-n_re) : $unsigned(n_re);
    n_im_mag = n_im[N_WIDTH-1] ? $unsigned(-n_im) : $unsigned(n_im);
    d_sum    = $unsigned(p_br_br) + $unsigned(p_bi_bi);
  end

  always_comb begin
`ifdef FIX_C_DIV_ROUND_EN
    // Quotient carries one extra fraction bit: add half an LSB, drop it.
    mag_re = ({1'b0, dq_re} + (Q_WIDTH+1)'(1)) >> 1;
    mag_im = ({1'b0, dq_im} + (Q_WIDTH+1)'(1)) >> 1;
`else
    mag_re = {1'b0, dq_re};
    mag_im = {1'b0, dq_im};
`endif
    {sat_re, val_re} = clamp(mag_re, neg_re);
    {sat_im, val_im} = clamp(mag_im, neg_im);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid && in_ready) next_state = MULT;
      MULT:    next_state = DIV;
      DIV:     if (iter == LAST_ITER) next_state = SAT;
      SAT:     next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs are registered from next_state so that in_ready stays
  // low throughout reset and first rises on the clock after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (next_state == IDLE);
      out_valid <= (next_state == DONE);
    end
  end

  // Iteration counter: runs only while dividing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter <= '0;
    end else if (state == DIV) begin
      iter <= iter + ITER_WIDTH'(1);
    end else begin
      iter <= '0;
    end
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_re  <= '0;
      op_a_im  <= '0;
      op_b_re  <= '0;
      op_b_im  <= '0;
      dq_re    <= '0;
      dq_im    <= '0;
      rem_re   <= '0;
      rem_im   <= '0;
      divisor  <= '0;
      neg_re   <= 1'b0;
      neg_im   <= 1'b0;
      dz       <= 1'b0;
      out_R    <= '0;
      out_I    <= '0;
      sat      <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_a_re <= opa_R;
            op_a_im <= opa_I;
            op_b_re <= opb_R;
            op_b_im <= opb_I;
          end
        end
        MULT: begin
          dq_re   <= {n_re_mag, {SHIFT{1'b0}}};
          dq_im   <= {n_im_mag, {SHIFT{1'b0}}};
          rem_re  <= '0;
          rem_im  <= '0;
          divisor <= d_sum;
          neg_re  <= n_re[N_WIDTH-1];
          neg_im  <= n_im[N_WIDTH-1];
          dz      <= (d_sum == '0);
        end
        DIV: begin
          {rem_re, dq_re} <= div_step(rem_re, dq_re, divisor);
          {rem_im, dq_im} <= div_step(rem_im, dq_im, divisor);
        end
        SAT: begin
          // A zero divisor lets every trial subtract succeed; the quotient
          // bits are meaningless, so report full-scale positive instead.
          if (dz) begin
            out_R    <= POS_OUT;
            out_I    <= POS_OUT;
            sat      <= 1'b1;
            div_zero <= 1'b1;
          end else begin
            out_R    <= val_re;
            out_I    <= val_im;
            sat      <= sat_re | sat_im;
            div_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fix_c_div.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fix_c_div                                                |
// | Description : Directed self-checking bench for fix_c_div (default         |
// |               parameters). Honors FIX_C_DIV_ROUND_EN for expectations.    |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_fix_c_div;

  logic               clk       = 1'b0;
  logic               rst_n     = 1'b0;
  logic               in_valid  = 1'b0;
  logic               out_ready = 1'b0;
  logic signed [15:0] opa_R     = '0;
  logic signed [15:0] opa_I     = '0;
  logic signed [15:0] opb_R     = '0;
  logic signed [15:0] opb_I     = '0;
  logic               in_ready;
  logic               out_valid;
  logic signed [15:0] out_R;
  logic signed [15:0] out_I;
  logic               sat;
  logic               div_zero;

  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 0;

`ifdef FIX_C_DIV_ROUND_EN
  localparam int LAT     = 50;
  localparam int Q_2_3   = 10923;  // 2/3   * 16384 = 10922.67
  localparam int Q_11_25 = 7209;   // 11/25 * 16384 = 7208.96
  localparam int Q_2_25  = 1311;   // 2/25  * 16384 = 1310.72
`else
  localparam int LAT     = 49;
  localparam int Q_2_3   = 10922;
  localparam int Q_11_25 = 7208;
  localparam int Q_2_25  = 1310;
`endif

  fix_c_div #(
    .IN_WIDTH  (16),
    .OUT_WIDTH (16),
    .FRAC_BITS (14)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opa_R     (opa_R),
    .opa_I     (opa_I),
    .opb_R     (opb_R),
    .opb_I     (opb_I),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_R     (out_R),
    .out_I     (out_I),
    .sat       (sat),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait for in_ready, present operands for one accepting edge, then count
  // cycles until out_valid (bounded).
  task automatic do_op(input logic signed [15:0] ar, input logic signed [15:0] ai,
                       input logic signed [15:0] br, input logic signed [15:0] bi);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    opa_R = ar; opa_I = ai; opb_R = br; opb_I = bi;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic check_out(input string tag, input int er, input int ei,
                           input int es, input int edz);
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_out_R"}, out_R, er);
    check({tag, "_out_I"}, out_I, ei);
    check({tag, "_sat"}, sat, es);
    check({tag, "_div_zero"}, div_zero, edz);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, "_rel_in_ready"}, in_ready, 1);
    check({tag, "_rel_out_valid"}, out_valid, 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_R", out_R, 0);
    check("rst_out_I", out_I, 0);
    check("rst_sat", sat, 0);
    check("rst_div_zero", div_zero, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("rel_in_ready_low", in_ready, 0);
    @(posedge clk); #1;
    check("rel_in_ready_high", in_ready, 1);

    // (1,0)/(0,1) = -i, then hold DONE for 10 cycles with an in_valid pulse
    do_op(16'sd1, 16'sd0, 16'sd0, 16'sd1);
    check_out("a10_b01", 0, -16384, 0, 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_out_R", out_R, 0);
      check("hold_out_I", out_I, -16384);
      check("hold_sat", sat, 0);
      if (i == 3) begin
        opa_R = 16'sd7; opa_I = 16'sd7; opb_R = 16'sd1; opb_I = 16'sd0;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    release_out("hold");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("idle_after_ignored_pulse", in_ready, 1);
    end

    do_op(16'sd1, 16'sd1, 16'sd2, 16'sd0);
    check_out("a11_b20", 8192, 8192, 0, 0);
    release_out("a11_b20");

    do_op(16'sd2, 16'sd0, 16'sd3, 16'sd0);
    check_out("a20_b30", Q_2_3, 0, 0, 0);
    release_out("a20_b30");

    do_op(-16'sd2, 16'sd0, 16'sd3, 16'sd0);
    check_out("am20_b30", -Q_2_3, 0, 0, 0);
    release_out("am20_b30");

    do_op(16'sd32767, 16'sd0, 16'sd1, 16'sd0);
    check_out("pos_sat", 32767, 0, 1, 0);
    release_out("pos_sat");

    do_op(-16'sd32768, 16'sd0, 16'sd1, 16'sd0);
    check_out("neg_sat", -32768, 0, 1, 0);
    release_out("neg_sat");

    do_op(16'sd5, -16'sd5, 16'sd0, 16'sd0);
    check_out("div_zero", 32767, 32767, 1, 1);
    release_out("div_zero");

    do_op(16'sd0, 16'sd0, 16'sd3, 16'sd4);
    check_out("zero_num", 0, 0, 0, 0);
    release_out("zero_num");

    do_op(-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768);
    check_out("most_neg", 16384, 0, 0, 0);
    release_out("most_neg");

    do_op(-16'sd3, 16'sd0, 16'sd4, 16'sd0);
    check_out("am30_b40", -12288, 0, 0, 0);
    release_out("am30_b40");

    // Abort at DIV iteration 20; out_R still holds -12288 until reset hits
    @(posedge clk); #1;
    opa_R = 16'sd100; opa_I = 16'sd0; opb_R = 16'sd1; opb_I = 16'sd0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("abort_busy_in_ready", in_ready, 0);
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_out_R", out_R, 0);
    check("abort_out_I", out_I, 0);
    check("abort_sat", sat, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("abort_rel_in_ready_low", in_ready, 0);
    @(posedge clk); #1;
    check("abort_rel_in_ready_high", in_ready, 1);

    do_op(16'sd1, 16'sd2, 16'sd3, 16'sd4);
    check_out("after_abort", Q_11_25, Q_2_25, 0, 0);
    release_out("after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
